// File: rtl/error_counter_dac_if.sv
// Signal bundle between the error-angle level generator (master) and the
// error counter / DAC register (slave). LIMIT_HITS exists only with ERR_LIMIT_STICKY_EN.
interface error_counter_dac_if #(
    parameter int CNT_W = 10
);
    logic                    _UPLVL;
    logic                    _DNLVL;
    logic                    CNT_PULSE;
    logic                    ERR_EN;
    logic                    REF_STROBE;
    logic signed [CNT_W-1:0] ERR_CNT;
    logic [CNT_W-1:0]        ERR_DAC;
    logic                    AT_LIMIT;
    logic                    ILLEGAL;
`ifdef ERR_LIMIT_STICKY_EN
    logic [3:0]              LIMIT_HITS;
`endif

    modport master (
        output _UPLVL, _DNLVL, CNT_PULSE, ERR_EN, REF_STROBE,
`ifdef ERR_LIMIT_STICKY_EN
        input  LIMIT_HITS,
`endif
        input  ERR_CNT, ERR_DAC, AT_LIMIT, ILLEGAL
    );

    modport slave (
        input  _UPLVL, _DNLVL, CNT_PULSE, ERR_EN, REF_STROBE,
`ifdef ERR_LIMIT_STICKY_EN
        output LIMIT_HITS,
`endif
        output ERR_CNT, ERR_DAC, AT_LIMIT, ILLEGAL
    );
endinterface

// File: rtl/error_counter_dac.sv
// Saturating up/down error counter with offset-binary DAC word register.
// Optional macro ERR_LIMIT_STICKY_EN: sticky AT_LIMIT plus LIMIT_HITS counter.
//
// state    | meaning
// DISABLED | counter held at 0, count events ignored, DAC reloads mid-scale
// ACTIVE   | count events step the counter with saturation at +/-LIMIT
module error_counter_dac #(
    parameter int CNT_W = 10,
    parameter int LIMIT = 384
) (
    input  logic              clk,
    input  logic              rst_n,
    error_counter_dac_if.slave bus
);
    typedef enum logic {DISABLED = 1'b0, ACTIVE = 1'b1} state_t;

    localparam logic signed [CNT_W-1:0] POS_LIM = CNT_W'(LIMIT);
    localparam logic signed [CNT_W-1:0] NEG_LIM = -POS_LIM;
    localparam logic signed [CNT_W-1:0] ONE     = CNT_W'(1);

    logic cnt_s1, cnt_s2, cnt_s3;
    logic ref_s1, ref_s2, ref_s3;
    logic up_s1, up_s2, dn_s1, dn_s2;
    logic en_s1, en_s2;

    state_t                  state;
    logic signed [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0]        err_dac;
    logic                    illegal;

    logic cnt_evt, ref_evt, step_up, step_dn, both_low, at_pos, at_neg;

    // Level synchronisers idle at 1 so a reset never looks like a command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_s1 <= 1'b0;
            cnt_s2 <= 1'b0;
            cnt_s3 <= 1'b0;
            ref_s1 <= 1'b0;
            ref_s2 <= 1'b0;
            ref_s3 <= 1'b0;
            up_s1  <= 1'b1;
            up_s2  <= 1'b1;
            dn_s1  <= 1'b1;
            dn_s2  <= 1'b1;
            en_s1  <= 1'b0;
            en_s2  <= 1'b0;
        end else begin
            cnt_s1 <= bus.CNT_PULSE;
            cnt_s2 <= cnt_s1;
            cnt_s3 <= cnt_s2;
            ref_s1 <= bus.REF_STROBE;
            ref_s2 <= ref_s1;
            ref_s3 <= ref_s2;
            up_s1  <= bus._UPLVL;
            up_s2  <= up_s1;
            dn_s1  <= bus._DNLVL;
            dn_s2  <= dn_s1;
            en_s1  <= bus.ERR_EN;
            en_s2  <= en_s1;
        end
    end

    assign cnt_evt  = cnt_s2 & ~cnt_s3;
    assign ref_evt  = ref_s2 & ~ref_s3;
    assign step_up  = cnt_evt & ~up_s2 &  dn_s2;
    assign step_dn  = cnt_evt &  up_s2 & ~dn_s2;
    assign both_low = cnt_evt & ~up_s2 & ~dn_s2;
    assign at_pos   = (err_cnt == POS_LIM);
    assign at_neg   = (err_cnt == NEG_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= DISABLED;
            err_cnt <= '0;
            err_dac <= $unsigned(POS_LIM);
            illegal <= 1'b0;
        end else begin
            illegal <= 1'b0;
            // DAC samples the counter before any same-cycle count update.
            if (ref_evt) begin
                if (state == DISABLED) begin
                    err_dac <= $unsigned(POS_LIM);
                end else begin
                    err_dac <= $unsigned(err_cnt + POS_LIM);
                end
            end
            case (state)
                DISABLED: begin
                    err_cnt <= '0;
                    if (en_s2) begin
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (!en_s2) begin
                        state   <= DISABLED;
                        err_cnt <= '0;
                    end else begin
                        if (step_up && !at_pos) begin
                            err_cnt <= err_cnt + ONE;
                        end else if (step_dn && !at_neg) begin
                            err_cnt <= err_cnt - ONE;
                        end
                        illegal <= both_low;
                    end
                end
                default: begin
                    state   <= DISABLED;
                    err_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.ERR_CNT = err_cnt;
    assign bus.ERR_DAC = err_dac;
    assign bus.ILLEGAL = illegal;

`ifdef ERR_LIMIT_STICKY_EN
    logic       sticky_q;
    logic [3:0] hits_q;
    logic       rejected;

    assign rejected = (state == ACTIVE) & en_s2 & ((step_up & at_pos) | (step_dn & at_neg));

    // Cleared in DISABLED and on the edge that leaves ACTIVE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
            hits_q   <= '0;
        end else if ((state == DISABLED) || !en_s2) begin
            sticky_q <= 1'b0;
            hits_q   <= '0;
        end else begin
            sticky_q <= sticky_q | at_pos | at_neg;
            if (rejected && (hits_q != 4'hF)) begin
                hits_q <= hits_q + 4'd1;
            end
        end
    end

    assign bus.AT_LIMIT   = sticky_q | at_pos | at_neg;
    assign bus.LIMIT_HITS = hits_q;
`else
    assign bus.AT_LIMIT = at_pos | at_neg;
`endif
endmodule

// File: tb/tb_error_counter_dac.sv
// Scoreboard bench for error_counter_dac; handles both ERR_LIMIT_STICKY_EN builds.
module tb_error_counter_dac;
    localparam int CNT_W = 10;
    localparam int LIMIT = 384;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    error_counter_dac_if #(.CNT_W(CNT_W)) bus();

    error_counter_dac #(.CNT_W(CNT_W), .LIMIT(LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    int model_cnt    = 0;
    int model_hits   = 0;
    bit model_sticky = 1'b0;
    bit model_active = 1'b0;

    logic signed [CNT_W-1:0] cnt_q[$];
    logic [CNT_W-1:0]        dac_q[$];
    logic signed [CNT_W-1:0] exp_c;
    logic [CNT_W-1:0]        exp_d;

    function automatic bit exp_at_limit();
`ifdef ERR_LIMIT_STICKY_EN
        return model_sticky;
`else
        return (model_cnt == LIMIT) || (model_cnt == -LIMIT);
`endif
    endfunction

    task automatic model_step();
        if (!model_active) return;
        if (!bus._UPLVL && bus._DNLVL) begin
            if (model_cnt == LIMIT) model_hits = (model_hits < 15) ? model_hits + 1 : 15;
            else model_cnt = model_cnt + 1;
        end else if (bus._UPLVL && !bus._DNLVL) begin
            if (model_cnt == -LIMIT) model_hits = (model_hits < 15) ? model_hits + 1 : 15;
            else model_cnt = model_cnt - 1;
        end
        if ((model_cnt == LIMIT) || (model_cnt == -LIMIT)) model_sticky = 1'b1;
    endtask

    task automatic set_levels(input logic up_n, input logic dn_n);
        @(negedge clk);
        bus._UPLVL = up_n;
        bus._DNLVL = dn_n;
        repeat (3) @(negedge clk);
    endtask

    task automatic set_enable(input logic en);
        @(negedge clk);
        bus.ERR_EN = en;
        repeat (5) @(negedge clk);
        model_active = en;
        if (!en) begin
            model_cnt    = 0;
            model_hits   = 0;
            model_sticky = 1'b0;
        end
    endtask

    // Drives one count pulse (optionally with a coincident strobe) and queues expectations.
    task automatic drive_pulse(input bit with_strobe);
        if (with_strobe) dac_q.push_back(model_active ? CNT_W'(model_cnt + LIMIT) : CNT_W'(LIMIT));
        model_step();
        cnt_q.push_back(CNT_W'(model_cnt));
        @(negedge clk);
        bus.CNT_PULSE = 1'b1;
        if (with_strobe) bus.REF_STROBE = 1'b1;
        repeat (3) @(negedge clk);
        bus.CNT_PULSE  = 1'b0;
        bus.REF_STROBE = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic drive_strobe();
        dac_q.push_back(model_active ? CNT_W'(model_cnt + LIMIT) : CNT_W'(LIMIT));
        @(negedge clk);
        bus.REF_STROBE = 1'b1;
        repeat (3) @(negedge clk);
        bus.REF_STROBE = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (bus.ERR_CNT !== '0) begin
            bad++; $display("FAIL reset_cnt: got %0d expected 0", $signed(bus.ERR_CNT));
        end
        total++;
        if (bus.ERR_DAC !== CNT_W'(LIMIT)) begin
            bad++; $display("FAIL reset_dac: got %0d expected %0d", bus.ERR_DAC, LIMIT);
        end
        total++;
        if (bus.AT_LIMIT !== 1'b0 || bus.ILLEGAL !== 1'b0) begin
            bad++; $display("FAIL reset_flags: got at_limit=%b illegal=%b expected 0 0", bus.AT_LIMIT, bus.ILLEGAL);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_count_up();
        set_levels(1'b0, 1'b1);
        set_enable(1'b1);
        for (int i = 0; i < 5; i++) begin
            drive_pulse(1'b0);
            exp_c = cnt_q.pop_front();
            total++;
            if (bus.ERR_CNT !== exp_c) begin
                bad++; $display("FAIL count_up[%0d]: got %0d expected %0d", i, $signed(bus.ERR_CNT), exp_c);
            end
        end
        drive_strobe();
        exp_d = dac_q.pop_front();
        total++;
        if (bus.ERR_DAC !== exp_d || exp_d !== CNT_W'(389)) begin
            bad++; $display("FAIL dac_after_5: got %0d expected %0d", bus.ERR_DAC, exp_d);
        end
    endtask

    task automatic test_saturate();
        set_enable(1'b0);
        total++;
        if (bus.ERR_CNT !== '0) begin
            bad++; $display("FAIL clear_on_disable: got %0d expected 0", $signed(bus.ERR_CNT));
        end
        set_enable(1'b1);
        set_levels(1'b1, 1'b0);
        for (int i = 0; i < 392; i++) begin
            drive_pulse(1'b0);
            exp_c = cnt_q.pop_front();
            total++;
            if (bus.ERR_CNT !== exp_c) begin
                bad++; $display("FAIL count_down[%0d]: got %0d expected %0d", i, $signed(bus.ERR_CNT), exp_c);
            end
        end
        total++;
        if (bus.AT_LIMIT !== 1'b1) begin
            bad++; $display("FAIL at_limit_neg: got %b expected 1", bus.AT_LIMIT);
        end
        set_levels(1'b0, 1'b1);
        drive_pulse(1'b0);
        exp_c = cnt_q.pop_front();
        total++;
        if (bus.ERR_CNT !== exp_c || exp_c !== -CNT_W'(383)) begin
            bad++; $display("FAIL back_off: got %0d expected %0d", $signed(bus.ERR_CNT), exp_c);
        end
        total++;
        if (bus.AT_LIMIT !== exp_at_limit()) begin
            bad++; $display("FAIL at_limit_back_off: got %b expected %b", bus.AT_LIMIT, exp_at_limit());
        end
`ifdef ERR_LIMIT_STICKY_EN
        total++;
        if (bus.LIMIT_HITS !== 4'(model_hits)) begin
            bad++; $display("FAIL limit_hits: got %0d expected %0d", bus.LIMIT_HITS, model_hits);
        end
`endif
    endtask

    task automatic test_illegal();
        int highs;
        set_levels(1'b0, 1'b0);
        highs = 0;
        model_step();
        cnt_q.push_back(CNT_W'(model_cnt));
        @(negedge clk);
        bus.CNT_PULSE = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 2) bus.CNT_PULSE = 1'b0;
            if (bus.ILLEGAL === 1'b1) highs++;
        end
        total++;
        if (highs != 1) begin
            bad++; $display("FAIL illegal_width: got %0d cycles expected 1", highs);
        end
        exp_c = cnt_q.pop_front();
        total++;
        if (bus.ERR_CNT !== exp_c) begin
            bad++; $display("FAIL illegal_hold: got %0d expected %0d", $signed(bus.ERR_CNT), exp_c);
        end
        set_levels(1'b1, 1'b1);
    endtask

    task automatic test_disable();
        set_enable(1'b0);
        set_enable(1'b1);
        set_levels(1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            drive_pulse(1'b0);
            exp_c = cnt_q.pop_front();
            total++;
            if (bus.ERR_CNT !== exp_c) begin
                bad++; $display("FAIL up_to_20[%0d]: got %0d expected %0d", i, $signed(bus.ERR_CNT), exp_c);
            end
        end
        // Enable drops on the same edge the pulse rises: the pulse must be lost.
        @(negedge clk);
        bus.ERR_EN    = 1'b0;
        bus.CNT_PULSE = 1'b1;
        model_active = 1'b0; model_cnt = 0; model_hits = 0; model_sticky = 1'b0;
        cnt_q.push_back('0);
        repeat (3) @(negedge clk);
        bus.CNT_PULSE = 1'b0;
        repeat (3) @(negedge clk);
        exp_c = cnt_q.pop_front();
        total++;
        if (bus.ERR_CNT !== exp_c) begin
            bad++; $display("FAIL disable_discard: got %0d expected %0d", $signed(bus.ERR_CNT), exp_c);
        end
        for (int i = 0; i < 3; i++) begin
            drive_pulse(1'b0);
            exp_c = cnt_q.pop_front();
            total++;
            if (bus.ERR_CNT !== exp_c) begin
                bad++; $display("FAIL disabled_hold[%0d]: got %0d expected %0d", i, $signed(bus.ERR_CNT), exp_c);
            end
        end
        drive_strobe();
        exp_d = dac_q.pop_front();
        total++;
        if (bus.ERR_DAC !== exp_d) begin
            bad++; $display("FAIL dac_disabled: got %0d expected %0d", bus.ERR_DAC, exp_d);
        end
`ifdef ERR_LIMIT_STICKY_EN
        total++;
        if (bus.LIMIT_HITS !== 4'd0 || bus.AT_LIMIT !== 1'b0) begin
            bad++; $display("FAIL sticky_clear: got hits=%0d at_limit=%b expected 0 0", bus.LIMIT_HITS, bus.AT_LIMIT);
        end
`endif
        set_enable(1'b1);
        drive_pulse(1'b0);
        exp_c = cnt_q.pop_front();
        total++;
        if (bus.ERR_CNT !== exp_c || exp_c !== CNT_W'(1)) begin
            bad++; $display("FAIL reenable_up: got %0d expected %0d", $signed(bus.ERR_CNT), exp_c);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            drive_pulse(1'b0);
            exp_c = cnt_q.pop_front();
            total++;
            if (bus.ERR_CNT !== exp_c) begin
                bad++; $display("FAIL up_to_7[%0d]: got %0d expected %0d", i, $signed(bus.ERR_CNT), exp_c);
            end
        end
        drive_pulse(1'b1);
        exp_c = cnt_q.pop_front();
        exp_d = dac_q.pop_front();
        total++;
        if (bus.ERR_CNT !== exp_c || exp_c !== CNT_W'(8)) begin
            bad++; $display("FAIL coincident_cnt: got %0d expected %0d", $signed(bus.ERR_CNT), exp_c);
        end
        total++;
        if (bus.ERR_DAC !== exp_d || exp_d !== CNT_W'(391)) begin
            bad++; $display("FAIL coincident_dac: got %0d expected %0d", bus.ERR_DAC, exp_d);
        end
        drive_strobe();
        exp_d = dac_q.pop_front();
        total++;
        if (bus.ERR_DAC !== exp_d || exp_d !== CNT_W'(392)) begin
            bad++; $display("FAIL next_strobe_dac: got %0d expected %0d", bus.ERR_DAC, exp_d);
        end
    endtask

    task automatic test_reset_mid();
        set_enable(1'b0);
        set_enable(1'b1);
        set_levels(1'b1, 1'b0);
        for (int i = 0; i < 100; i++) begin
            drive_pulse(1'b0);
            exp_c = cnt_q.pop_front();
            if (i == 99) begin
                total++;
                if (bus.ERR_CNT !== exp_c) begin
                    bad++; $display("FAIL down_to_m100: got %0d expected %0d", $signed(bus.ERR_CNT), exp_c);
                end
            end
        end
        drive_strobe();
        void'(dac_q.pop_front());
        @(negedge clk);
        bus.CNT_PULSE = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (bus.ERR_CNT !== '0 || bus.ERR_DAC !== CNT_W'(LIMIT) || bus.AT_LIMIT !== 1'b0 || bus.ILLEGAL !== 1'b0) begin
            bad++; $display("FAIL reset_mid: got cnt=%0d dac=%0d at=%b ill=%b expected 0 %0d 0 0",
                            $signed(bus.ERR_CNT), bus.ERR_DAC, bus.AT_LIMIT, bus.ILLEGAL, LIMIT);
        end
        model_cnt = 0; model_hits = 0; model_sticky = 1'b0;
        @(negedge clk);
        bus.CNT_PULSE = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        total++;
        if (bus.ERR_CNT !== '0) begin
            bad++; $display("FAIL no_count_after_reset: got %0d expected 0", $signed(bus.ERR_CNT));
        end
        drive_pulse(1'b0);
        exp_c = cnt_q.pop_front();
        total++;
        if (bus.ERR_CNT !== exp_c || exp_c !== -CNT_W'(1)) begin
            bad++; $display("FAIL fresh_pulse: got %0d expected %0d", $signed(bus.ERR_CNT), exp_c);
        end
    endtask

    initial begin
        bus._UPLVL     = 1'b1;
        bus._DNLVL     = 1'b1;
        bus.CNT_PULSE  = 1'b0;
        bus.ERR_EN     = 1'b0;
        bus.REF_STROBE = 1'b0;
        test_reset();
        test_count_up();
        test_saturate();
        test_illegal();
        test_disable();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
